// File: rtl/kernel_vlanes_pkg.sv
// Shared definitions for the multi-lane streaming map kernel.
package kernel_vlanes_pkg;

  // Per-beat lane operation, applied identically to every lane.
  typedef enum logic [1:0] {
    MODE_ADD   = 2'b00,
    MODE_SUB   = 2'b01,
    MODE_MAX   = 2'b10,
    MODE_PASSA = 2'b11
  } mode_e;

  // Output buffer depth in beats.
  localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/kernel_top_vlanes_if.sv
// Input/output stream bundle for kernel_top_vlanes: one valid/ready pair
// per direction, lane vectors packed lane i at [i*STREAMW +: STREAMW].
interface kernel_top_vlanes_if #(
  parameter int unsigned STREAMW = 32,
  parameter int unsigned NLANES  = 16
);
  logic                        ivalid;
  logic                        iready;
  logic [NLANES*STREAMW-1:0]   vin_a;
  logic [NLANES*STREAMW-1:0]   vin_b;
  logic [1:0]                  mode;
  logic                        ovalid;
  logic                        oready;
  logic [NLANES*STREAMW-1:0]   vout;
  logic [31:0]                 beat_cnt;

  // Environment side: produces input beats, consumes output beats.
  modport master (
    output ivalid, vin_a, vin_b, mode, oready,
    input  iready, ovalid, vout, beat_cnt
  );

  // Kernel side.
  modport slave (
    input  ivalid, vin_a, vin_b, mode, oready,
    output iready, ovalid, vout, beat_cnt
  );
endinterface

// File: rtl/kernel_vlane_alu.sv
// One lane of the map kernel: mode-selected ALU followed by the stage-0
// result register, which advances only on the global enable.
module kernel_vlane_alu
  import kernel_vlanes_pkg::*;
#(
  parameter int unsigned STREAMW = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [STREAMW-1:0] a_i,
  input  logic [STREAMW-1:0] b_i,
  input  mode_e              mode_i,
  output logic [STREAMW-1:0] res_o
);

  logic [STREAMW-1:0] res_d;
  logic [STREAMW-1:0] res_q;

  // Lane operation; add/sub wrap to STREAMW bits, max is signed.
  always_comb begin
    res_d = a_i;
    case (mode_i)
      MODE_ADD:   res_d = a_i + b_i;
      MODE_SUB:   res_d = a_i - b_i;
      MODE_MAX:   res_d = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
      MODE_PASSA: res_d = a_i;
      default:    res_d = a_i;
    endcase
  end

  // Stage-0 result register, held while the pipeline is stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_q <= '0;
    end else if (en_i) begin
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/kernel_top_vlanes.sv
// NLANES lock-step lanes of a streaming map kernel: per-lane ALU in
// stage 0, PIPE_D-1 pure delay stages, a 2-entry registered output buffer
// and a completed-transfer counter, all behind one valid/ready handshake.
module kernel_top_vlanes
  import kernel_vlanes_pkg::*;
#(
  parameter int unsigned STREAMW = 32,
  parameter int unsigned NLANES  = 16,
  parameter int unsigned PIPE_D  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  kernel_top_vlanes_if.slave   bus
);

  localparam int unsigned VW = NLANES * STREAMW;

  logic              en;
  logic              wr;
  logic              rd;
  logic              full;
  logic              v_last;
  logic [PIPE_D-1:0] v_q;
  logic [VW-1:0]     s0_data;
  logic [VW-1:0]     last_data;

  logic [1:0]        cnt_q,  cnt_d;
  logic [VW-1:0]     head_q, head_d;
  logic [VW-1:0]     tail_q, tail_d;
  logic [31:0]       beat_cnt_q;

  // Stall only when a valid beat is waiting to enter a full buffer; uses
  // the registered count so iready never depends on oready combinationally.
  assign v_last = v_q[PIPE_D-1];
  assign full   = (cnt_q == 2'(FIFO_DEPTH));
  assign en     = ~(v_last & full);
  assign wr     = en & v_last;
  assign rd     = (cnt_q != 2'd0) & bus.oready;

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    kernel_vlane_alu #(
      .STREAMW (STREAMW)
    ) u_alu (
      .clk_i  (clk),
      .rst_ni (rst),
      .en_i   (en),
      .a_i    (bus.vin_a[l*STREAMW +: STREAMW]),
      .b_i    (bus.vin_b[l*STREAMW +: STREAMW]),
      .mode_i (mode_e'(bus.mode)),
      .res_o  (s0_data[l*STREAMW +: STREAMW])
    );
  end

  // Valid chain: stage 0 takes ivalid, later stages shift, bubbles included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
    end else if (en) begin
      v_q[0] <= bus.ivalid;
      for (int unsigned k = 1; k < PIPE_D; k++) begin
        v_q[k] <= v_q[k-1];
      end
    end
  end

  if (PIPE_D > 1) begin : g_dly
    logic [VW-1:0] dly_q [PIPE_D-1];

    // Pure delay stages behind the ALU register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int unsigned k = 0; k < PIPE_D - 1; k++) begin
          dly_q[k] <= '0;
        end
      end else if (en) begin
        dly_q[0] <= s0_data;
        for (int unsigned k = 1; k < PIPE_D - 1; k++) begin
          dly_q[k] <= dly_q[k-1];
        end
      end
    end

    assign last_data = dly_q[PIPE_D-2];
  end else begin : g_nodly
    assign last_data = s0_data;
  end

  // Two-entry buffer kept as head/tail registers so vout comes straight
  // from a flop; a read shifts tail into head, a write fills the first
  // free slot (head directly when the only entry is leaving).
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({wr, rd})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = last_data;
        else               tail_d = last_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = last_data;
        end else begin
          head_d = tail_q;
          tail_d = last_data;
        end
      end
      default: ;
    endcase
  end

  // Buffer state and completed-transfer counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      if (rd) beat_cnt_q <= beat_cnt_q + 32'd1;
    end
  end

  assign bus.iready   = en;
  assign bus.ovalid   = (cnt_q != 2'd0);
  assign bus.vout     = head_q;
  assign bus.beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_kernel_top_vlanes.sv
// Self-checking bench for kernel_top_vlanes: a beat-level queue model
// checked every cycle, plus directed literal expectations.
module tb_kernel_top_vlanes;
  import kernel_vlanes_pkg::*;

  localparam int unsigned SW = 32;
  localparam int unsigned NL = 16;
  localparam int unsigned PD = 2;
  localparam int unsigned VW = SW * NL;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  kernel_top_vlanes_if #(.STREAMW(SW), .NLANES(NL)) bus ();

  kernel_top_vlanes #(
    .STREAMW (SW),
    .NLANES  (NL),
    .PIPE_D  (PD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] lane_ref(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                             input logic [1:0] m);
    case (m)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return ($signed(a) >= $signed(b)) ? a : b;
      default: return a;
    endcase
  endfunction

  function automatic logic [VW-1:0] vec_ref(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                            input logic [1:0] m);
    logic [VW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*SW +: SW] = lane_ref(a[i*SW +: SW], b[i*SW +: SW], m);
    return r;
  endfunction

  function automatic logic [VW-1:0] rep(input logic [SW-1:0] x);
    return {NL{x}};
  endfunction

  // ---------------- model / scoreboard ----------------
  logic [VW-1:0] expq[$];
  logic [31:0]   exp_cnt        = '0;
  int            cyc            = 0;
  int            acc_total      = 0;
  int            out_total      = 0;
  int            first_acc_edge = -1;
  int            first_out_cyc  = -1;
  int            last_out_cyc   = -1;

  always @(posedge clk) cyc++;

  // Mid-cycle sampling: a handshake seen here completes at the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      expq.delete();
      exp_cnt        = '0;
      first_acc_edge = -1;
      first_out_cyc  = -1;
      last_out_cyc   = -1;
    end else begin
      chk("beat_cnt", VW'(bus.beat_cnt), VW'(exp_cnt));
      if (bus.ovalid) begin
        if (first_out_cyc < 0) first_out_cyc = cyc;
        chk("ovalid_has_beat", VW'(expq.size() != 0), VW'(1));
        if (expq.size() != 0) chk("vout", bus.vout, expq[0]);
        if (bus.oready) begin
          if (expq.size() != 0) void'(expq.pop_front());
          exp_cnt++;
          out_total++;
          last_out_cyc = cyc;
        end
      end
      if (bus.ivalid && bus.iready) begin
        expq.push_back(vec_ref(bus.vin_a, bus.vin_b, bus.mode));
        acc_total++;
        if (first_acc_edge < 0) first_acc_edge = cyc + 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_beat(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [1:0] m);
    int n = 0;
    bus.ivalid = 1'b1;
    bus.vin_a  = a;
    bus.vin_b  = b;
    bus.mode   = m;
    @(negedge clk);
    while (!bus.iready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("accept_in_time", VW'(bus.iready), VW'(1));
    @(posedge clk); #1;
    bus.ivalid = 1'b0;
  endtask

  task automatic wait_out(input string nm, input logic [VW-1:0] exp);
    int n = 0;
    @(negedge clk);
    while (!bus.ovalid && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_ovalid"}, VW'(bus.ovalid), VW'(1));
    chk(nm, bus.vout, exp);
    @(posedge clk); #1;
  endtask

  task automatic rand_vec(output logic [VW-1:0] v);
    for (int i = 0; i < NL; i++) v[i*SW +: SW] = $urandom;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [SW-1:0] ta [5];
    logic [SW-1:0] tb [5];
    logic [1:0]    tm [5];
    logic [SW-1:0] te [5];
    logic [VW-1:0] va, vb, ve;
    int            n, a0, o0, irdy_low, stale, r;

    bus.ivalid = 1'b0;
    bus.oready = 1'b0;
    bus.vin_a  = '0;
    bus.vin_b  = '0;
    bus.mode   = 2'b00;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_iready",   VW'(bus.iready),   VW'(1));
    chk("rst_ovalid",   VW'(bus.ovalid),   VW'(0));
    chk("rst_vout",     bus.vout,          VW'(0));
    chk("rst_beat_cnt", VW'(bus.beat_cnt), VW'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    // Pin the reference model to hand-computed values
    chk("ref_add_wrap", VW'(lane_ref(32'hFFFF_FFFF, 32'd1, MODE_ADD)), VW'(32'h0000_0000));
    chk("ref_sub_wrap", VW'(lane_ref(32'h0000_0000, 32'd1, MODE_SUB)), VW'(32'hFFFF_FFFF));
    chk("ref_max_neg",  VW'(lane_ref(32'hFFFF_FFFE, 32'd3, MODE_MAX)), VW'(32'd3));
    chk("ref_passa",    VW'(lane_ref(32'hDEAD_BEEF, 32'd9, MODE_PASSA)), VW'(32'hDEAD_BEEF));

    // Mode vectors, uniform across lanes, literal expectations
    ta = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFE, 32'h1234_5678, 32'h7FFF_FFFF};
    tb = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0003, 32'h9ABC_DEF0, 32'h8000_0000};
    tm = '{2'b00,         2'b01,         2'b10,         2'b11,         2'b10};
    te = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0003, 32'h1234_5678, 32'h7FFF_FFFF};
    bus.oready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_beat(rep(ta[i]), rep(tb[i]), tm[i]);
      wait_out($sformatf("mode_vec%0d", i), rep(te[i]));
      if (i == 0) chk("latency_single", VW'(first_out_cyc - first_acc_edge), VW'(PD));
    end

    // Lane packing: lane i = 0x100*i, minus 7
    for (int i = 0; i < NL; i++) begin
      va[i*SW +: SW] = 32'h100 * i;
      vb[i*SW +: SW] = 32'd7;
      ve[i*SW +: SW] = 32'h100 * i - 32'd7;
    end
    drive_beat(va, vb, MODE_SUB);
    wait_out("lane_packing", ve);
    chk("lane0_literal",  VW'(ve[0 +: SW]),     VW'(32'hFFFF_FFF9));
    chk("lane15_literal", VW'(ve[15*SW +: SW]), VW'(32'h0000_0EF9));

    // Reset with 3 beats in flight
    bus.oready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ivalid = 1'b1;
      bus.vin_a  = rep(32'hA0 + i);
      bus.vin_b  = rep(32'h1);
      bus.mode   = MODE_ADD;
      @(posedge clk); #1;
    end
    bus.ivalid = 1'b0;
    chk("pre_reset_ovalid", VW'(bus.ovalid), VW'(1));
    rst = 1'b0;
    #1;
    chk("midrst_ovalid",   VW'(bus.ovalid),   VW'(0));
    chk("midrst_vout",     bus.vout,          VW'(0));
    chk("midrst_beat_cnt", VW'(bus.beat_cnt), VW'(0));
    chk("midrst_iready",   VW'(bus.iready),   VW'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    bus.oready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.ovalid) stale++;
    end
    chk("no_stale_after_reset", VW'(stale), VW'(0));
    @(posedge clk); #1;

    // Throughput: 100 back-to-back beats with oready held high
    o0 = out_total;
    irdy_low = 0;
    for (int i = 0; i < 100; i++) begin
      rand_vec(va);
      rand_vec(vb);
      bus.ivalid = 1'b1;
      bus.vin_a  = va;
      bus.vin_b  = vb;
      bus.mode   = 2'(i % 4);
      @(negedge clk);
      if (!bus.iready) irdy_low++;
      @(posedge clk); #1;
    end
    bus.ivalid = 1'b0;
    n = 0;
    while (out_total - o0 < 100 && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("tp_out_count",   VW'(out_total - o0),               VW'(100));
    chk("tp_latency",     VW'(first_out_cyc - first_acc_edge), VW'(PD));
    chk("tp_consecutive", VW'(last_out_cyc - first_out_cyc),   VW'(99));
    chk("tp_beat_cnt",    VW'(bus.beat_cnt),                 VW'(100));
    chk("tp_iready_high", VW'(irdy_low),                     VW'(0));
    @(posedge clk); #1;

    // Back-pressure: oready low, continuous ivalid
    bus.oready = 1'b0;
    a0 = acc_total;
    o0 = out_total;
    for (int i = 0; i < 10; i++) begin
      bus.ivalid = 1'b1;
      bus.vin_a  = rep(32'h50 + i);
      bus.vin_b  = rep(32'h3);
      bus.mode   = MODE_SUB;
      @(negedge clk);
      if (i == 9) chk("bp_iready_low", VW'(bus.iready), VW'(0));
      @(posedge clk); #1;
    end
    bus.ivalid = 1'b0;
    chk("bp_accepted", VW'(acc_total - a0), VW'(PD + 2));
    bus.oready = 1'b1;
    n = 0;
    while (expq.size() != 0 && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("bp_delivered",      VW'(out_total - o0), VW'(PD + 2));
    chk("bp_iready_restore", VW'(bus.iready),     VW'(1));
    @(posedge clk); #1;

    // Random ivalid/oready, random mode per beat
    a0 = acc_total;
    n  = 0;
    while (acc_total - a0 < 10000 && n < 60000) begin
      n++;
      r = int'(bus.iready);
      bus.oready = 1'($urandom_range(0, 1));
      #1;
      chk("iready_indep_oready", VW'(bus.iready), VW'(r));
      rand_vec(va);
      rand_vec(vb);
      bus.ivalid = 1'($urandom_range(0, 1));
      bus.vin_a  = va;
      bus.vin_b  = vb;
      bus.mode   = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    bus.ivalid = 1'b0;
    chk("rand_beats", VW'(acc_total - a0 >= 10000), VW'(1));
    bus.oready = 1'b1;
    n = 0;
    while (expq.size() != 0 && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    chk("rand_drained", VW'(expq.size()), VW'(0));
    @(posedge clk); #1;

    // beat_cnt wrap
    force dut.beat_cnt_q = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.beat_cnt_q;
    @(negedge clk);
    chk("wrap_preload", VW'(bus.beat_cnt), VW'(32'hFFFF_FFFF));
    @(posedge clk); #1;
    drive_beat(rep(32'd5), rep(32'd6), MODE_ADD);
    wait_out("wrap_beat", rep(32'd11));
    @(negedge clk);
    chk("wrap_zero", VW'(bus.beat_cnt), VW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kernel_top_vlanes.md
# kernel_top_vlanes

Parametrised successor to the single-lane kernel top. It processes NLANES lock-step lanes of a streaming map kernel behind one valid/ready handshake. Each lane runs a mode-selectable ALU through a PIPE_D-deep stall pipeline, and a registered 2-entry output buffer decouples downstream back-pressure. It sits between the stream fabric and the memory-side output stream, in place of the per-kernel top wrappers.

## Interface
- STREAMW, 32: lane data width in bits (≥8).
- NLANES, 16: number of lanes (≥1); all lanes share one handshake.
- PIPE_D, 2: ALU pipeline stages (≥1).
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-low (rst=0 resets, assertion async, deassertion sampled by clk).
- ivalid  in  1  input beat valid.
- iready  out  1  block can accept an input beat this cycle.
- vin_a  in  NLANES*STREAMW  operand A; lane i is bits [i*STREAMW +: STREAMW].
- vin_b  in  NLANES*STREAMW  operand B, same packing.
- mode  in  2  operation, sampled with each accepted beat.
- ovalid  out  1  output beat valid.
- oready  in  1  downstream accepts output beat.
- vout  out  NLANES*STREAMW  result vector, same packing.
- beat_cnt  out  32  count of completed output transfers.

## Operation
- Input transfer when ivalid & iready at a clock edge; output transfer when ovalid & oready.
- Per-lane op by mode, applied to every lane:
  - 00: a+b. Two's-complement wrap, low STREAMW bits kept.
  - 01: a−b. Wrap.
  - 10: signed max(a,b).
  - 11: pass a.
- mode travels with its beat through the pipeline; changing mode between beats never affects beats already in flight.
- ALU result is computed in stage 0. Stages 1..PIPE_D−1 are pure delay. Each stage has a valid bit.
- Global advance enable: en = ~(v[PIPE_D−1] & fifo_full). When en=0, every stage holds, bubbles included.
- iready = en. It depends only on registered state, never combinationally on oready or ivalid.
- On en, stage 0 loads the new beat (valid=ivalid). Stage k loads stage k−1. If v[PIPE_D−1]=1, the FIFO is written.
- Output FIFO:
  - 2 entries. ovalid = ~empty. vout = head entry, driven from a register.
  - Simultaneous write and read keeps the count unchanged.
  - No write occurs while full, even if a read happens in the same cycle. This follows from en using the registered full flag.
- beat_cnt increments by 1 on each output transfer and wraps 2^32−1 → 0.
- Reset, including mid-operation: all stage valids are cleared, the FIFO is emptied, and in-flight beats are discarded.

## Timing
- Reset values: iready=1 (FIFO empty), ovalid=0, vout=0, beat_cnt=0.
- Latency: beat accepted at edge E0 with no stall → ovalid with that result after edge E0+PIPE_D. With PIPE_D=2: accepted edge 0, ovalid after edge 2.
- Throughput: 1 beat/cycle while oready=1 continuously. In that case the FIFO never exceeds 1 entry and iready stays 1.
- With oready=0 held: the FIFO fills after 2 beats reach it, then iready drops once a valid beat sits in the last stage. Capacity before iready=0 is PIPE_D+2 beats when ivalid is continuous.
- Once oready rises, iready returns to 1 on the cycle after the FIFO leaves full.
- Order is strictly preserved: no beat is lost or duplicated under any ivalid/oready pattern.

## Structure
- Package kernel_vlanes_pkg holds the mode constants MODE_ADD=2'b00, MODE_SUB=2'b01, MODE_MAX=2'b10, MODE_PASSA=2'b11.
- Sub-module kernel_vlane_alu: one lane, combinational op plus stage-0 register, parameter STREAMW. Instantiated NLANES times by generate.
- Delay stages, valid chain, 2-entry FIFO and counter are implemented in the top module.

## Test plan
- Reset: rst=0 mid-stream with 3 beats in flight → ovalid=0, vout=0, beat_cnt=0, iready=1. After rst=1, no stale beat appears.
- Modes, NLANES=16, STREAMW=32:
  - a=0xFFFF_FFFF, b=1, mode 00 → 0x0000_0000.
  - a=0, b=1, mode 01 → 0xFFFF_FFFF.
  - a=0xFFFF_FFFE (−2), b=3, mode 10 → 3.
  - mode 11 → a.
  - Lane i must carry the value in bits [i*32+:32].
- Latency/throughput, PIPE_D=2, oready=1: 100 back-to-back beats → first ovalid 2 edges after the first accept. Then 100 consecutive output beats, beat_cnt=100.
- Back-pressure: oready=0 with continuous ivalid → exactly 4 beats accepted, then iready=0. Release oready → all 4 delivered in order, no loss.
- Random ivalid/oready (50% each), 10 000 beats, per-beat random mode: scoreboard matches exactly, order preserved, iready never depends combinationally on oready.
- beat_cnt wrap: force the counter to 0xFFFF_FFFF, complete one transfer → beat_cnt=0.
